// File: rtl/if_id_pkg.sv
// Shared RV32I decode constants and the opcode-class enum used by the
// fetch/decode front end.
package if_id_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_ARITHI = 7'b0010011;
    localparam logic [6:0] OPC_ARITHR = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam int OPCODE_LO   = 0;
    localparam int OPCODE_HI   = 6;
    localparam int RD_LO       = 7;
    localparam int RD_HI       = 11;
    localparam int FUNC3_LO    = 12;
    localparam int FUNC3_HI    = 14;
    localparam int RS1_LO      = 15;
    localparam int RS1_HI      = 19;
    localparam int RS2_LO      = 20;
    localparam int RS2_HI      = 24;
    localparam int SUBTYPE_BIT = 30;

    typedef enum logic [3:0] {
        ALU_I, ALU_R, LOAD, STORE, BRANCH, JAL, JALR, LUI, ILLEGAL
    } opclass_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic is_shift(input logic [2:0] func3);
        return (func3 == F3_SLL) || (func3 == F3_SR);
    endfunction

endpackage

// File: rtl/rv32_imm_decode.sv
// Combinational RV32I immediate extraction and opcode classification
// for a single instruction word.
module rv32_imm_decode
    import if_id_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [31:0] immediate,
    output logic [3:0]  opclass
);

    logic [6:0] opcode;
    logic [2:0] func3;
    opclass_t   cls;

    assign opcode  = instruction[OPCODE_HI:OPCODE_LO];
    assign func3   = instruction[FUNC3_HI:FUNC3_LO];
    assign opclass = cls;

    always_comb begin
        cls       = ILLEGAL;
        immediate = 32'h0;
        case (opcode)
            OPC_ARITHI: begin
                cls = ALU_I;
                // Shift-immediates carry only a 5-bit shamt; bit 30 is the SRA flag.
                if (is_shift(func3))
                    immediate = {27'h0, instruction[24:20]};
                else
                    immediate = {{20{instruction[31]}}, instruction[31:20]};
            end
            OPC_ARITHR: begin
                cls = ALU_R;
            end
            OPC_LOAD: begin
                cls       = LOAD;
                immediate = {{20{instruction[31]}}, instruction[31:20]};
            end
            OPC_JALR: begin
                cls       = JALR;
                immediate = {{20{instruction[31]}}, instruction[31:20]};
            end
            OPC_STORE: begin
                cls       = STORE;
                immediate = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            end
            OPC_BRANCH: begin
                cls       = BRANCH;
                immediate = {{19{instruction[31]}}, instruction[31], instruction[7],
                             instruction[30:25], instruction[11:8], 1'b0};
            end
            OPC_LUI: begin
                cls       = LUI;
                immediate = {instruction[31:12], 12'h0};
            end
            OPC_JAL: begin
                cls       = JAL;
                immediate = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                             instruction[20], instruction[30:21], 1'b0};
            end
            default: begin
                cls       = ILLEGAL;
                immediate = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/if_id_queue.sv
// RV32I fetch/decode front end: fetch PC generation, DEPTH-entry prefetch
// queue, registered decode stage and sticky exception capture.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter logic [31:0] RESET = 32'h0000_0000,
    parameter int          DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_mem_req,
    output logic [31:0] inst_mem_address,
    input  logic        inst_mem_is_valid,
    input  logic [31:0] inst_mem_read_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction,
    output logic [31:0] out_immediate,
    output logic [3:0]  out_opclass,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [2:0]  out_func3,
    output logic        out_subtype,
    output logic        out_illegal,
    output logic        exception,
    output logic [31:0] exception_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      q_pc   [DEPTH];
    logic [31:0]      q_word [DEPTH];
    logic [DEPTH-1:0] q_mis;

    logic [31:0]      pc_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic        out_valid_reg;
    logic [31:0] out_pc_reg;
    logic [31:0] out_instruction_reg;
    logic [31:0] out_immediate_reg;
    logic [3:0]  out_opclass_reg;
    logic [4:0]  out_rs1_reg;
    logic [4:0]  out_rs2_reg;
    logic [4:0]  out_rd_reg;
    logic [2:0]  out_func3_reg;
    logic        out_subtype_reg;
    logic        out_illegal_reg;
    logic        exception_reg;
    logic [31:0] exception_pc_reg;

    logic        accept;
    logic        dequeue;
    logic [31:0] head_word;
    logic [31:0] head_pc;
    logic [31:0] head_immediate;
    logic [3:0]  head_opclass;
    logic        head_subtype;
    logic        head_illegal;

    // Request depends on registered occupancy only, never on stall/redirect.
    assign inst_mem_req     = (count_reg != CNT_W'(DEPTH));
    assign inst_mem_address = pc_reg;

    assign accept  = inst_mem_req && inst_mem_is_valid && !redirect;
    assign dequeue = (count_reg != '0) && (!out_valid_reg || !stall) && !redirect;

    assign head_word = q_word[rd_ptr_reg];
    assign head_pc   = q_pc[rd_ptr_reg];

    rv32_imm_decode u_imm_decode (
        .instruction (head_word),
        .immediate   (head_immediate),
        .opclass     (head_opclass)
    );

    assign head_subtype = ((head_word[OPCODE_HI:OPCODE_LO] == OPC_ARITHI) &&
                           (head_word[FUNC3_HI:FUNC3_LO] == F3_ADD)) ? 1'b0
                          : head_word[SUBTYPE_BIT];
    assign head_illegal = (head_opclass == 4'(ILLEGAL)) || q_mis[rd_ptr_reg];

    // Queue storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_pc[wr_ptr_reg]   <= pc_reg;
            q_word[wr_ptr_reg] <= inst_mem_read_data;
            q_mis[wr_ptr_reg]  <= (pc_reg[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg     <= RESET;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (redirect) begin
            pc_reg     <= redirect_pc;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (accept) begin
                pc_reg     <= pc_reg + 32'd4;
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (dequeue)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({accept, dequeue})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg       <= 1'b0;
            out_pc_reg          <= '0;
            out_instruction_reg <= '0;
            out_immediate_reg   <= '0;
            out_opclass_reg     <= '0;
            out_rs1_reg         <= '0;
            out_rs2_reg         <= '0;
            out_rd_reg          <= '0;
            out_func3_reg       <= '0;
            out_subtype_reg     <= 1'b0;
            out_illegal_reg     <= 1'b0;
        end else if (redirect) begin
            out_valid_reg <= 1'b0;
        end else if (dequeue) begin
            out_valid_reg       <= 1'b1;
            out_pc_reg          <= head_pc;
            out_instruction_reg <= head_word;
            out_immediate_reg   <= head_immediate;
            out_opclass_reg     <= head_opclass;
            out_rs1_reg         <= head_word[RS1_HI:RS1_LO];
            out_rs2_reg         <= head_word[RS2_HI:RS2_LO];
            out_rd_reg          <= head_word[RD_HI:RD_LO];
            out_func3_reg       <= head_word[FUNC3_HI:FUNC3_LO];
            out_subtype_reg     <= head_subtype;
            out_illegal_reg     <= head_illegal;
        end else if (!stall) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Sticky: only reset clears it, so the first faulting PC survives redirects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exception_reg    <= 1'b0;
            exception_pc_reg <= '0;
        end else if (dequeue && head_illegal && !exception_reg) begin
            exception_reg    <= 1'b1;
            exception_pc_reg <= head_pc;
        end
    end

    assign out_valid       = out_valid_reg;
    assign out_pc          = out_pc_reg;
    assign out_instruction = out_instruction_reg;
    assign out_immediate   = out_immediate_reg;
    assign out_opclass     = out_opclass_reg;
    assign out_rs1         = out_rs1_reg;
    assign out_rs2         = out_rs2_reg;
    assign out_rd          = out_rd_reg;
    assign out_func3       = out_func3_reg;
    assign out_subtype     = out_subtype_reg;
    assign out_illegal     = out_illegal_reg;
    assign exception       = exception_reg;
    assign exception_pc    = exception_pc_reg;

endmodule

// File: tb/tb_if_id_queue.sv
// Randomised bench for if_id_queue: a queue-based transaction model predicts
// fetch address, request, decoded output and exception state every cycle.
module tb_if_id_queue;
    import if_id_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_mem_req;
    logic [31:0] inst_mem_address;
    logic        inst_mem_is_valid = 1'b0;
    logic [31:0] inst_mem_read_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc, out_instruction, out_immediate;
    logic [3:0]  out_opclass;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_func3;
    logic        out_subtype, out_illegal, exception;
    logic [31:0] exception_pc;

    logic [31:0] mem [256];
    assign inst_mem_read_data = mem[inst_mem_address[9:2]];

    always #5 clk = ~clk;

    if_id_queue #(.RESET(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .inst_mem_req(inst_mem_req), .inst_mem_address(inst_mem_address),
        .inst_mem_is_valid(inst_mem_is_valid), .inst_mem_read_data(inst_mem_read_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .out_valid(out_valid), .out_pc(out_pc), .out_instruction(out_instruction),
        .out_immediate(out_immediate), .out_opclass(out_opclass),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_func3(out_func3), .out_subtype(out_subtype), .out_illegal(out_illegal),
        .exception(exception), .exception_pc(exception_pc)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_qpc [$];
    logic [31:0] m_qw  [$];
    logic        m_valid;
    logic [31:0] m_out_pc, m_instr, m_imm;
    logic [3:0]  m_cls;
    logic        m_sub, m_ill, m_exc;
    logic [31:0] m_exc_pc;

    function automatic void ref_decode(input logic [31:0] w, output logic [31:0] imm,
                                       output logic [3:0] cls);
        int sgn;
        int v;
        sgn = $signed(w) >>> 31;   // -1 or 0
        v   = 0;
        case (w[6:0])
            7'h13: begin
                cls = 4'(ALU_I);
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) v = int'(w[24:20]);
                else v = $signed(w) >>> 20;
            end
            7'h33: cls = 4'(ALU_R);
            7'h03: begin cls = 4'(LOAD); v = $signed(w) >>> 20; end
            7'h67: begin cls = 4'(JALR); v = $signed(w) >>> 20; end
            7'h23: begin cls = 4'(STORE); v = ($signed(w) >>> 25) * 32 + int'(w[11:7]); end
            7'h63: begin
                cls = 4'(BRANCH);
                v = sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            end
            7'h6f: begin
                cls = 4'(JAL);
                v = sgn * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            end
            7'h37: begin cls = 4'(LUI); v = int'(w & 32'hFFFF_F000); end
            default: cls = 4'(ILLEGAL);
        endcase
        imm = v;
    endfunction

    function automatic void model_reset();
        m_pc = RST_PC;
        m_qpc.delete();
        m_qw.delete();
        m_valid = 0; m_out_pc = 0; m_instr = 0; m_imm = 0; m_cls = 0;
        m_sub = 0; m_ill = 0; m_exc = 0; m_exc_pc = 0;
    endfunction

    function automatic void model_edge();
        bit          acc, deq;
        logic [31:0] w;
        acc = (m_qpc.size() != DEPTH) && inst_mem_is_valid && !redirect;
        deq = (m_qpc.size() != 0) && (!m_valid || !stall) && !redirect;
        if (redirect) begin
            m_qpc.delete();
            m_qw.delete();
            m_valid = 0;
            m_pc = redirect_pc;
            return;
        end
        if (deq) begin
            m_out_pc = m_qpc.pop_front();
            m_instr  = m_qw.pop_front();
            m_valid  = 1;
            ref_decode(m_instr, m_imm, m_cls);
            m_sub = (m_instr[6:0] == 7'h13 && m_instr[14:12] == 3'd0) ? 1'b0 : m_instr[30];
            m_ill = (m_cls == 4'(ILLEGAL)) || (m_out_pc % 4 != 0);
            if (m_ill && !m_exc) begin
                m_exc = 1;
                m_exc_pc = m_out_pc;
            end
            $display("out pc=%h instr=%h imm=%h cls=%0d ill=%0b", m_out_pc, m_instr, m_imm, m_cls, m_ill);
        end else if (!stall) begin
            m_valid = 0;
        end
        if (acc) begin
            w = mem[m_pc[9:2]];
            m_qpc.push_back(m_pc);
            m_qw.push_back(w);
            m_pc = m_pc + 4;
        end
    endfunction

    task automatic compare_all();
        check("req", inst_mem_req, m_qpc.size() != DEPTH);
        check("addr", inst_mem_address, m_pc);
        check("valid", out_valid, m_valid);
        if (m_valid) begin
            check("out_pc", out_pc, m_out_pc);
            check("instr", out_instruction, m_instr);
            check("imm", out_immediate, m_imm);
            check("opclass", out_opclass, m_cls);
            check("rs1", out_rs1, m_instr[19:15]);
            check("rs2", out_rs2, m_instr[24:20]);
            check("rd", out_rd, m_instr[11:7]);
            check("func3", out_func3, m_instr[14:12]);
            check("subtype", out_subtype, m_sub);
            check("illegal", out_illegal, m_ill);
        end
        check("exception", exception, m_exc);
        check("exception_pc", exception_pc, m_exc_pc);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all();
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'h03;
            1: w[6:0] = 7'h23;
            2: w[6:0] = 7'h63;
            3: w[6:0] = 7'h6f;
            4: w[6:0] = 7'h67;
            5: w[6:0] = 7'h13;
            6: w[6:0] = 7'h33;
            7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h13;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = rand_word();
        mem[0] = 32'h0301_0413;
        mem[1] = 32'h0000_17b7;
        mem[2] = 32'h0217_8793;
        mem[8'h40] = NOP;
        mem[8'h80] = NOP;
        model_reset();

        // Reset state
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        compare_all();
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instruction, 0);
        check("rst_out_imm", out_immediate, 0);
        check("rst_out_opclass", out_opclass, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_illegal", out_illegal, 0);
        reset = 1'b1;

        // Back-to-back decode of three known words
        inst_mem_is_valid = 1'b1;
        stall = 1'b0;
        step();
        step();
        check("t1_pc0", out_pc, 32'h0);
        check("t1_imm0", out_immediate, 32'h30);
        check("t1_cls0", out_opclass, 4'(ALU_I));
        step();
        check("t1_pc4", out_pc, 32'h4);
        check("t1_imm4", out_immediate, 32'h1000);
        check("t1_cls4", out_opclass, 4'(LUI));
        step();
        check("t1_pc8", out_pc, 32'h8);
        check("t1_imm8", out_immediate, 32'h21);
        check("t1_cls8", out_opclass, 4'(ALU_I));

        // Downstream stall fills the queue
        stall = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("stall_req_low", inst_mem_req, 0);
        check("stall_hold_pc", out_pc, 32'h8);
        stall = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Redirect with three entries queued
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) step();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check("redir_valid", out_valid, 0);
        check("redir_addr", inst_mem_address, 32'h100);
        stall = 1'b0;
        step();
        step();
        check("redir_out_pc", out_pc, 32'h100);

        // Misaligned redirect target raises the exception
        redirect = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        step();
        step();
        check("mis_pc", out_pc, 32'h102);
        check("mis_illegal", out_illegal, 1);
        check("mis_exc", exception, 1);
        check("mis_exc_pc", exception_pc, 32'h102);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        step();
        step();
        check("post_pc", out_pc, 32'h200);
        check("post_illegal", out_illegal, 0);
        check("post_exc_pc", exception_pc, 32'h102);

        // Illegal opcode at PC 0x8
        mem[2] = 32'hFFFF_FFFF;
        do_reset();
        stall = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("ill_pc", out_pc, 32'h8);
        check("ill_cls", out_opclass, 4'(ILLEGAL));
        check("ill_imm", out_immediate, 0);
        check("ill_exc_pc", exception_pc, 32'h8);

        // Asynchronous reset while the queue is full and output stalled
        stall = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("full_req", inst_mem_req, 0);
        #2 reset = 1'b0;
        #1;
        check("areset_valid", out_valid, 0);
        check("areset_addr", inst_mem_address, RST_PC);
        check("areset_req", inst_mem_req, 1);
        check("areset_exc", exception, 0);
        model_reset();
        @(negedge clk);
        compare_all();
        reset = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            inst_mem_is_valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 49) == 0);
            redirect_pc = {22'h0, 8'($urandom), 2'b00};
            if ($urandom_range(0, 9) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
